decode_stage_hs: RTL

- Parametrised successor to the fixed 32-bit decode register. Sits between fetch and execute.
- Decodes one RV32I/RV64I base instruction per accepted beat into the shared ALU/load/store/branch control codes.
- Adds a valid/ready handshake with backpressure, bubble insertion, flush, illegal-instruction detection, and a saturating illegal counter.

---
 rtl/decode_stage_hs.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage_hs.sv
// rtl/decode_stage_hs.sv - RV32I/RV64I decode stage with valid/ready handshake, flush and illegal counter.
// Optional M-extension decode is enabled by defining DECODE_MEXT_EN.
`timescale 1ns/1ps
module decode_stage_hs #(
    parameter int XLEN  = 32,
    parameter int ALU_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      ir,
    input  logic [XLEN-1:0]  pc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       srcreg1_num,
    output logic [4:0]       srcreg2_num,
    output logic [4:0]       dstreg_num,
    output logic [XLEN-1:0]  imm,
    output logic [ALU_W-1:0] alucode,
    output logic             using_r2,
    output logic             using_pc,
    output logic             write_reg,
    output logic [2:0]       info_load,
    output logic [1:0]       info_store,
    output logic [3:0]       info_branch,
    output logic [XLEN-1:0]  pc_out,
    output logic [4:0]       ereg1_addr,
    output logic [4:0]       ereg2_addr,
    output logic             illegal,
`ifdef DECODE_MEXT_EN
    output logic             is_muldiv,
    output logic [2:0]       muldiv_op,
`endif
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [ALU_W-1:0] ALU_ADD    = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB    = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_SLL    = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_SLT    = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_SLTU   = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_XOR    = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_SRL    = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_SRA    = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALU_OR     = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALU_AND    = ALU_W'(9);
    localparam logic [ALU_W-1:0] ALU_LUI    = ALU_W'(10);
    localparam logic [ALU_W-1:0] ALU_UNUSED = {ALU_W{1'b1}};

    localparam logic [2:0] LD_NOT = 3'b111;
    localparam logic [1:0] ST_SB = 2'd1, ST_SH = 2'd2, ST_SW = 2'd3, ST_NOT = 2'd0;
    localparam logic [3:0] BR_NOT = 4'd0, BR_EQ = 4'd1, BR_NE = 4'd2, BR_LT = 4'd3, BR_GE = 4'd4,
                           BR_LTU = 4'd5, BR_GEU = 4'd6, BR_JAL = 4'd7, BR_JALR = 4'd8;

    localparam logic [6:0] OPC_OPIMM = 7'h13, OPC_OP = 7'h33, OPC_LUI = 7'h37, OPC_AUIPC = 7'h17,
                           OPC_JAL = 7'h6F, OPC_JALR = 7'h67, OPC_BRANCH = 7'h63,
                           OPC_STORE = 7'h23, OPC_LOAD = 7'h03;

    typedef struct packed {
        logic             ill;
        logic [4:0]       dst;
        logic [XLEN-1:0]  imm;
        logic [ALU_W-1:0] alu;
        logic             r2;
        logic             pcu;
        logic             wr;
        logic [2:0]       ld;
        logic [1:0]       st;
        logic [3:0]       br;
        logic [4:0]       e1;
        logic [4:0]       e2;
`ifdef DECODE_MEXT_EN
        logic             md;
        logic [2:0]       mop;
`endif
    } ctrl_t;

    function automatic ctrl_t clear_ctrl();
        ctrl_t c;
        c     = '0;
        c.alu = ALU_UNUSED;
        c.ld  = LD_NOT;
        c.st  = ST_NOT;
        c.br  = BR_NOT;
        return c;
    endfunction

    logic             valid_q;
    ctrl_t            ctrl_q;
    ctrl_t            dec;
    logic [XLEN-1:0]  pc_q;
    logic [CNT_W-1:0] cnt_q;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rs1, rs2;
    logic [5:0]      shamt6;
    logic            sh_zero, sh_alt;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc = ir[6:0];
    assign f3  = ir[14:12];
    assign f7  = ir[31:25];
    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];

    assign imm_i = XLEN'($signed(ir[31:20]));
    assign imm_s = XLEN'($signed({ir[31:25], ir[11:7]}));
    assign imm_b = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({ir[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));

    // On RV64 bit 25 belongs to the 6-bit shamt, so only ir[31:26] is reserved.
    assign shamt6  = (XLEN == 64) ? ir[25:20] : {1'b0, ir[24:20]};
    assign sh_zero = (XLEN == 64) ? (ir[31:26] == 6'b000000) : (f7 == 7'b0000000);
    assign sh_alt  = (XLEN == 64) ? (ir[31:26] == 6'b010000) : (f7 == 7'b0100000);

    always_comb begin
        dec     = clear_ctrl();
        dec.dst = ir[11:7];
        case (opc)
            OPC_OPIMM: begin
                dec.wr  = 1'b1;
                dec.e1  = rs1;
                dec.imm = imm_i;
                case (f3)
                    3'b000: dec.alu = ALU_ADD;
                    3'b010: dec.alu = ALU_SLT;
                    3'b011: dec.alu = ALU_SLTU;
                    3'b100: dec.alu = ALU_XOR;
                    3'b110: dec.alu = ALU_OR;
                    3'b111: dec.alu = ALU_AND;
                    3'b001: begin
                        dec.alu = ALU_SLL;
                        dec.imm = XLEN'(shamt6);
                        dec.ill = !sh_zero;
                    end
                    default: begin
                        dec.alu = ir[30] ? ALU_SRA : ALU_SRL;
                        dec.imm = XLEN'(shamt6);
                        dec.ill = !(sh_zero || sh_alt);
                    end
                endcase
            end
            OPC_OP: begin
                dec.wr = 1'b1;
                dec.r2 = 1'b1;
                dec.e1 = rs1;
                dec.e2 = rs2;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  dec.alu = ALU_ADD;
                        3'b001:  dec.alu = ALU_SLL;
                        3'b010:  dec.alu = ALU_SLT;
                        3'b011:  dec.alu = ALU_SLTU;
                        3'b100:  dec.alu = ALU_XOR;
                        3'b101:  dec.alu = ALU_SRL;
                        3'b110:  dec.alu = ALU_OR;
                        default: dec.alu = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    dec.alu = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    dec.alu = ALU_SRA;
`ifdef DECODE_MEXT_EN
                end else if (f7 == 7'b0000001) begin
                    dec.md  = 1'b1;
                    dec.mop = f3;
`endif
                end else begin
                    dec.ill = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.wr  = 1'b1;
                dec.alu = ALU_LUI;
                dec.imm = imm_u;
            end
            OPC_AUIPC: begin
                dec.wr  = 1'b1;
                dec.pcu = 1'b1;
                dec.alu = ALU_ADD;
                dec.imm = imm_u;
            end
            OPC_JAL: begin
                dec.wr  = 1'b1;
                dec.pcu = 1'b1;
                dec.alu = ALU_ADD;
                dec.imm = imm_j;
                dec.br  = BR_JAL;
            end
            OPC_JALR: begin
                dec.wr  = 1'b1;
                dec.alu = ALU_ADD;
                dec.imm = imm_i;
                dec.br  = BR_JALR;
                dec.e1  = rs1;
                dec.ill = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.pcu = 1'b1;
                dec.alu = ALU_ADD;
                dec.imm = imm_b;
                dec.e1  = rs1;
                dec.e2  = rs2;
                case (f3)
                    3'b000:  dec.br = BR_EQ;
                    3'b001:  dec.br = BR_NE;
                    3'b100:  dec.br = BR_LT;
                    3'b101:  dec.br = BR_GE;
                    3'b110:  dec.br = BR_LTU;
                    3'b111:  dec.br = BR_GEU;
                    default: dec.ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                // The 2-bit store code has no slot left for a doubleword store.
                dec.alu = ALU_ADD;
                dec.imm = imm_s;
                dec.e1  = rs1;
                dec.e2  = rs2;
                case (f3)
                    3'b000:  dec.st = ST_SB;
                    3'b001:  dec.st = ST_SH;
                    3'b010:  dec.st = ST_SW;
                    default: dec.ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.wr  = 1'b1;
                dec.alu = ALU_ADD;
                dec.imm = imm_i;
                dec.e1  = rs1;
                dec.ld  = f3;
                dec.ill = (XLEN == 64) ? (f3 == 3'b111)
                                       : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            end
            default: dec.ill = 1'b1;
        endcase
        if (dec.ill || ir[1:0] != 2'b11) begin
            dec     = clear_ctrl();
            dec.dst = ir[11:7];
            dec.ill = 1'b1;
        end
    end

    assign in_ready = !valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= clear_ctrl();
            pc_q    <= '0;
            cnt_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= clear_ctrl();
        end else if (in_ready) begin
            if (in_valid) begin
                valid_q <= 1'b1;
                ctrl_q  <= dec;
                pc_q    <= pc_in;
                if (dec.ill && cnt_q != {CNT_W{1'b1}}) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                valid_q <= 1'b0;
                ctrl_q  <= clear_ctrl();
            end
        end
    end

    assign srcreg1_num = rs1;
    assign srcreg2_num = rs2;
    assign out_valid   = valid_q;
    assign illegal     = ctrl_q.ill;
    assign dstreg_num  = ctrl_q.dst;
    assign imm         = ctrl_q.imm;
    assign alucode     = ctrl_q.alu;
    assign using_r2    = ctrl_q.r2;
    assign using_pc    = ctrl_q.pcu;
    assign write_reg   = ctrl_q.wr;
    assign info_load   = ctrl_q.ld;
    assign info_store  = ctrl_q.st;
    assign info_branch = ctrl_q.br;
    assign ereg1_addr  = ctrl_q.e1;
    assign ereg2_addr  = ctrl_q.e2;
    assign pc_out      = pc_q;
    assign illegal_cnt = cnt_q;
`ifdef DECODE_MEXT_EN
    assign is_muldiv   = ctrl_q.md;
    assign muldiv_op   = ctrl_q.mop;
`endif

endmodule
